// File: rtl/mmio_dump_initiator.sv
// ============================================================================
// mmio_dump_initiator : end-of-test MMIO writer (trap, register dump, stream, stop)
// Revision 1.0
// ============================================================================
`default_nettype none

module mmio_dump_initiator #(
  parameter int unsigned    XLEN            = 64,
  parameter int unsigned    AW              = 32,
  parameter int unsigned    STREAM_DEPTH    = 4,
  parameter logic [AW-1:0]  ADDR_STOP       = 32'h6000_0000,
  parameter logic [AW-1:0]  ADDR_TRAP       = 32'h6000_0008,
  parameter logic [AW-1:0]  ADDR_REG_DUMP   = 32'h6000_0010,
  parameter logic [AW-1:0]  ADDR_REG_STREAM = 32'h6000_0020
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dump_req_i,
  input  logic                trap_i,
  input  logic                stream_valid_i,
  output logic                stream_ready_o,
  input  logic [XLEN-1:0]     stream_data_i,
  input  logic [XLEN-1:0]     stream_data_t0_i,
  output logic [4:0]          rf_raddr_o,
  input  logic [XLEN-1:0]     rf_rdata_i,
  input  logic [XLEN-1:0]     rf_rdata_t0_i,
  output logic                mmio_req_o,
  output logic                mmio_we_o,
  output logic [AW-1:0]       mmio_addr_o,
  output logic [XLEN/8-1:0]   mmio_strb_o,
  output logic [XLEN-1:0]     mmio_wdata_o,
  output logic [XLEN-1:0]     mmio_wdata_o_t0,
  input  logic                mmio_gnt_i,
  output logic                busy_o,
  output logic                stopped_o
);

  localparam int unsigned PW = $clog2(STREAM_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD        = 3'd1;
  localparam logic [2:0] S_CAP       = 3'd2;
  localparam logic [2:0] S_WR        = 3'd3;
  localparam logic [2:0] S_STOP_WAIT = 3'd4;
  localparam logic [2:0] S_STOP_WR   = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [1:0] K_TRAP   = 2'd0;
  localparam logic [1:0] K_STREAM = 2'd1;
  localparam logic [1:0] K_DUMP   = 2'd2;
  localparam logic [1:0] K_STOP   = 2'd3;

  logic [2:0]      state_q, state_d;
  logic [4:0]      idx_q;
  logic            trap_pend_q;
  logic [XLEN-1:0] buf_q, buf_t0_q;

  logic [XLEN-1:0] fifo_data_q [STREAM_DEPTH];
  logic [XLEN-1:0] fifo_t0_q   [STREAM_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic            req_q, req_d;
  logic [1:0]      kind_q, kind_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] wt0_q, wt0_d;

  logic            w_done, w_free, w_trap_done, w_dump_done, w_stop_done;
  logic            w_push, w_pop, w_trap_cand, w_fifo_cand;
  logic            w_dump_cand, w_stop_cand, w_launch_en;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [CW-1:0]   w_cnt_after;

  assign w_done      = req_q & mmio_gnt_i;
  assign w_free      = ~req_q | mmio_gnt_i;
  assign w_trap_done = w_done & (kind_q == K_TRAP);
  assign w_pop       = w_done & (kind_q == K_STREAM);
  assign w_dump_done = w_done & (kind_q == K_DUMP);
  assign w_stop_done = w_done & (kind_q == K_STOP);

  // Candidates are evaluated as they will stand after this edge's grant,
  // so a following beat can launch back-to-back with the completing one.
  assign w_rd_ptr_nxt = rd_ptr_q + PW'(w_pop);
  assign w_cnt_after  = cnt_q - CW'(w_pop);
  assign w_trap_cand  = trap_pend_q & ~w_trap_done;
  assign w_fifo_cand  = (w_cnt_after != '0);
  assign w_launch_en  = w_free & ~w_stop_done & (state_q != S_HALT);

  assign stream_ready_o = (cnt_q != CW'(STREAM_DEPTH)) & ~stopped_o;
  assign w_push         = stream_valid_i & stream_ready_o;
  assign rf_raddr_o     = idx_q;

  // ---------------- dump FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- dump FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (dump_req_i) state_d = S_RD;
      S_RD:        state_d = S_CAP;
      S_CAP:       state_d = S_WR;
      S_WR:        if (w_dump_done) state_d = (idx_q == 5'd31) ? S_STOP_WAIT : S_RD;
      S_STOP_WAIT: if (!w_trap_cand && !w_fifo_cand) state_d = S_STOP_WR;
      S_STOP_WR:   if (w_stop_done) state_d = S_HALT;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------- dump FSM: outputs ----------------
  // The dump beat is offered already in CAP (data straight from the read
  // port) and the stop beat in STOP_WAIT, so neither loses a cycle.
  always_comb begin
    busy_o      = 1'b0;
    stopped_o   = 1'b0;
    w_dump_cand = 1'b0;
    w_stop_cand = 1'b0;
    case (state_q)
      S_RD:        busy_o = 1'b1;
      S_CAP: begin
        busy_o      = 1'b1;
        w_dump_cand = 1'b1;
      end
      S_WR: begin
        busy_o      = 1'b1;
        w_dump_cand = ~(req_q & (kind_q == K_DUMP));
      end
      S_STOP_WAIT: begin
        busy_o      = 1'b1;
        w_stop_cand = ~w_trap_cand & ~w_fifo_cand;
      end
      S_STOP_WR: begin
        busy_o      = 1'b1;
        w_stop_cand = ~(req_q & (kind_q == K_STOP));
      end
      S_HALT:      stopped_o = 1'b1;
      default:     ;
    endcase
  end

  // ---------------- beat arbiter ----------------
  always_comb begin
    req_d   = req_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wt0_d   = wt0_q;
    if (w_done) begin
      req_d   = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      wt0_d   = '0;
    end
    if (w_launch_en) begin
      if (w_trap_cand) begin
        req_d   = 1'b1;
        kind_d  = K_TRAP;
        addr_d  = ADDR_TRAP;
        wdata_d = '0;
        wt0_d   = '0;
      end else if (w_fifo_cand) begin
        req_d   = 1'b1;
        kind_d  = K_STREAM;
        addr_d  = ADDR_REG_STREAM;
        wdata_d = fifo_data_q[w_rd_ptr_nxt];
        wt0_d   = fifo_t0_q[w_rd_ptr_nxt];
      end else if (w_dump_cand) begin
        req_d   = 1'b1;
        kind_d  = K_DUMP;
        addr_d  = ADDR_REG_DUMP;
        wdata_d = (state_q == S_CAP) ? rf_rdata_i    : buf_q;
        wt0_d   = (state_q == S_CAP) ? rf_rdata_t0_i : buf_t0_q;
      end else if (w_stop_cand) begin
        req_d   = 1'b1;
        kind_d  = K_STOP;
        addr_d  = ADDR_STOP;
        wdata_d = '0;
        wt0_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q       <= 1'b0;
      kind_q      <= K_TRAP;
      addr_q      <= '0;
      wdata_q     <= '0;
      wt0_q       <= '0;
      idx_q       <= 5'd0;
      trap_pend_q <= 1'b0;
      buf_q       <= '0;
      buf_t0_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      req_q       <= req_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wt0_q       <= wt0_d;
      trap_pend_q <= (trap_pend_q & ~w_trap_done) | (trap_i & (state_q != S_HALT));
      if (state_q == S_IDLE && dump_req_i)    idx_q <= 5'd1;
      else if (w_dump_done && idx_q != 5'd31) idx_q <= idx_q + 5'd1;
      if (state_q == S_CAP) begin
        buf_q    <= rf_rdata_i;
        buf_t0_q <= rf_rdata_t0_i;
      end
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= w_rd_ptr_nxt;
      cnt_q    <= cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= stream_data_i;
      fifo_t0_q[wr_ptr_q]   <= stream_data_t0_i;
    end
  end

  assign mmio_req_o      = req_q;
  assign mmio_we_o       = req_q;
  assign mmio_addr_o     = addr_q;
  assign mmio_strb_o     = {(XLEN/8){req_q}};
  assign mmio_wdata_o    = wdata_q;
  assign mmio_wdata_o_t0 = wt0_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_dump_initiator.sv
// ============================================================================
// tb_mmio_dump_initiator : directed/randomized bench with beat scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mmio_dump_initiator;

  localparam logic [31:0] A_STOP   = 32'h6000_0000;
  localparam logic [31:0] A_TRAP   = 32'h6000_0008;
  localparam logic [31:0] A_DUMP   = 32'h6000_0010;
  localparam logic [31:0] A_STREAM = 32'h6000_0020;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] d;
    logic [63:0] t;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_req = 1'b0, trap = 1'b0, s_valid = 1'b0, s_ready;
  logic [63:0] s_data = '0, s_t0 = '0;
  logic [4:0]  rf_raddr;
  logic [63:0] rf_rdata = '0, rf_t0 = '0;
  logic        m_req, m_we, m_gnt = 1'b1, busy, stopped;
  logic [31:0] m_addr;
  logic [7:0]  m_strb;
  logic [63:0] m_wdata, m_t0;

  beat_t       got[$];
  beat_t       exp_q[$];
  logic [63:0] regs [32];
  logic [63:0] tregs [32];
  logic [63:0] sv [5];
  logic [63:0] st [5];
  int          checks = 0;
  int          failures = 0;
  int          gnt_mode = 0;
  int          stall_cnt = 0;

  mmio_dump_initiator dut (
    .clk_i(clk), .rst_ni(rst_n), .dump_req_i(dump_req), .trap_i(trap),
    .stream_valid_i(s_valid), .stream_ready_o(s_ready),
    .stream_data_i(s_data), .stream_data_t0_i(s_t0),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata), .rf_rdata_t0_i(rf_t0),
    .mmio_req_o(m_req), .mmio_we_o(m_we), .mmio_addr_o(m_addr),
    .mmio_strb_o(m_strb), .mmio_wdata_o(m_wdata), .mmio_wdata_o_t0(m_t0),
    .mmio_gnt_i(m_gnt), .busy_o(busy), .stopped_o(stopped)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    rf_rdata <= regs[rf_raddr];
    rf_t0    <= tregs[rf_raddr];
  end

  // Grant driver: 0 = tied high, 1 = five low cycles per beat, 2 = held low.
  always @(posedge clk) begin
    #2;
    case (gnt_mode)
      0: m_gnt = 1'b1;
      1: begin
        if (m_req) begin
          if (stall_cnt == 5) begin
            m_gnt = 1'b1;
            stall_cnt = 0;
          end else begin
            m_gnt = 1'b0;
            stall_cnt++;
          end
        end else begin
          m_gnt = 1'b0;
          stall_cnt = 0;
        end
      end
      default: m_gnt = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic [63:0] d, input logic [63:0] t);
    beat_t b;
    b.addr = a;
    b.d    = d;
    b.t    = t;
    return b;
  endfunction

  // Beat monitor plus handshake-rule checks, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr;
  logic [63:0] p_d, p_t;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("we_eq_req", {63'd0, m_we}, {63'd0, m_req});
      check("strb", {56'd0, m_strb}, m_req ? 64'hFF : 64'h0);
      if (prev_stall) begin
        check("stall_req", {63'd0, m_req}, 64'd1);
        check("stall_addr", {32'd0, m_addr}, {32'd0, p_addr});
        check("stall_wdata", m_wdata, p_d);
        check("stall_t0", m_t0, p_t);
      end
      if (m_req && m_gnt) got.push_back(mk(m_addr, m_wdata, m_t0));
      prev_stall = m_req && !m_gnt;
      p_addr = m_addr;
      p_d    = m_wdata;
      p_t    = m_t0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dump_req = 1'b0;
    trap = 1'b0;
    s_valid = 1'b0;
    gnt_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic fill_regs(input bit plan);
    for (int i = 0; i < 32; i++) begin
      regs[i]  = plan ? 64'h1000 + 64'(i) : {$urandom, $urandom};
      tregs[i] = plan ? 64'(i) << 8       : {$urandom, $urandom};
    end
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic exp_dumps(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(mk(A_DUMP, regs[i], tregs[i]));
  endtask

  task automatic wait_raddr(input logic [4:0] v, input int budget);
    int n = 0;
    while (rf_raddr !== v && n < budget) begin
      tick();
      n++;
    end
    check("wait_raddr", {59'd0, rf_raddr}, {59'd0, v});
  endtask

  task automatic wait_stopped(input int budget);
    int n = 0;
    while (stopped !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_stopped", {63'd0, stopped}, 64'd1);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), {32'd0, got[i].addr}, {32'd0, exp_q[i].addr});
      check($sformatf("%s_data[%0d]", tag, i), got[i].d, exp_q[i].d);
      check($sformatf("%s_taint[%0d]", tag, i), got[i].t, exp_q[i].t);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   {63'd0, m_req}, 64'd0);
    check({tag, "_we"},    {63'd0, m_we}, 64'd0);
    check({tag, "_addr"},  {32'd0, m_addr}, 64'd0);
    check({tag, "_strb"},  {56'd0, m_strb}, 64'd0);
    check({tag, "_wdata"}, m_wdata, 64'd0);
    check({tag, "_t0"},    m_t0, 64'd0);
    check({tag, "_raddr"}, {59'd0, rf_raddr}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_stop"},  {63'd0, stopped}, 64'd0);
    check({tag, "_ready"}, {63'd0, s_ready}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // ---- 1: plan register values, gnt tied high, latency ----
    fill_regs(1'b1);
    do_reset();
    check_idle_outputs("reset");
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    check("busy_after_req", {63'd0, busy}, 64'd1);
    check("raddr_first", {59'd0, rf_raddr}, 64'd1);
    tick();
    check("req_at_1", {63'd0, m_req}, 64'd0);
    tick();
    check("req_at_2", {63'd0, m_req}, 64'd1);
    check("first_addr", {32'd0, m_addr}, {32'd0, A_DUMP});
    check("first_wdata", m_wdata, 64'h1001);
    check("first_t0", m_t0, 64'h100);
    n = 2;
    while (!stopped && n < 200) begin
      tick();
      n++;
    end
    check("stop_latency", 64'(n), 64'd95);
    check("busy_after_stop", {63'd0, busy}, 64'd0);
    exp_dumps(1, 31);
    exp_q.push_back(mk(A_STOP, 64'd0, 64'd0));
    repeat (3) tick();
    compare_beats("plan");

    // ---- 2: random registers, five stall cycles per beat ----
    do_reset();
    fill_regs(1'b0);
    gnt_mode = 1;
    start_dump();
    wait_stopped(1500);
    exp_dumps(1, 31);
    exp_q.push_back(mk(A_STOP, 64'd0, 64'd0));
    repeat (3) tick();
    compare_beats("stall");

    // ---- 3: stream FIFO fills to depth with gnt low ----
    do_reset();
    gnt_mode = 2;
    sv[0] = 64'hAA; sv[1] = 64'hBB; sv[2] = 64'hCC; sv[3] = 64'hDD; sv[4] = 64'hEE;
    for (int i = 0; i < 5; i++) begin
      st[i]   = {$urandom, $urandom};
      s_valid = 1'b1;
      s_data  = sv[i];
      s_t0    = st[i];
      check($sformatf("fifo_ready[%0d]", i), {63'd0, s_ready}, (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    s_valid = 1'b0;
    check("fifo_head_req", {63'd0, m_req}, 64'd1);
    check("fifo_head_addr", {32'd0, m_addr}, {32'd0, A_STREAM});
    check("fifo_head_data", m_wdata, 64'hAA);
    gnt_mode = 0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(A_STREAM, sv[i], st[i]));
    compare_beats("fifo");
    check("fifo_ready_drained", {63'd0, s_ready}, 64'd1);
    check("fifo_busy", {63'd0, busy}, 64'd0);

    // ---- 4: coalesced trap ahead of dump beat x10 ----
    do_reset();
    fill_regs(1'b0);
    start_dump();
    wait_raddr(5'd10, 100);
    gnt_mode = 2;
    for (int p = 0; p < 3; p++) begin
      trap = 1'b1;
      tick();
      trap = 1'b0;
      tick();
    end
    check("trap_outstanding", {32'd0, m_addr}, {32'd0, A_TRAP});
    gnt_mode = 0;
    wait_stopped(300);
    exp_dumps(1, 9);
    exp_q.push_back(mk(A_TRAP, 64'd0, 64'd0));
    exp_dumps(10, 31);
    exp_q.push_back(mk(A_STOP, 64'd0, 64'd0));
    repeat (3) tick();
    compare_beats("trap");

    // ---- 5: stream entries queued behind the last dump beat ----
    do_reset();
    fill_regs(1'b0);
    start_dump();
    wait_raddr(5'd31, 200);
    gnt_mode = 2;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      sv[i]   = {$urandom, $urandom};
      st[i]   = {$urandom, $urandom};
      s_valid = 1'b1;
      s_data  = sv[i];
      s_t0    = st[i];
      check($sformatf("late_ready[%0d]", i), {63'd0, s_ready}, 64'd1);
      tick();
    end
    s_valid = 1'b0;
    gnt_mode = 0;
    wait_stopped(100);
    exp_dumps(1, 31);
    exp_q.push_back(mk(A_STREAM, sv[0], st[0]));
    exp_q.push_back(mk(A_STREAM, sv[1], st[1]));
    exp_q.push_back(mk(A_STOP, 64'd0, 64'd0));
    trap = 1'b1;
    dump_req = 1'b1;
    s_valid = 1'b1;
    check("halt_ready", {63'd0, s_ready}, 64'd0);
    tick();
    trap = 1'b0;
    dump_req = 1'b0;
    s_valid = 1'b0;
    repeat (20) tick();
    compare_beats("halt");
    check("halt_req", {63'd0, m_req}, 64'd0);
    check("halt_stopped", {63'd0, stopped}, 64'd1);
    check("halt_busy", {63'd0, busy}, 64'd0);

    // ---- 6: asynchronous reset during RD of x17, then restart ----
    do_reset();
    fill_regs(1'b0);
    start_dump();
    wait_raddr(5'd17, 100);
    exp_dumps(1, 16);
    compare_beats("pre_reset");
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    start_dump();
    check("restart_raddr", {59'd0, rf_raddr}, 64'd1);
    wait_stopped(200);
    exp_dumps(1, 31);
    exp_q.push_back(mk(A_STOP, 64'd0, 64'd0));
    repeat (3) tick();
    compare_beats("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
